// File: rtl/mirror_period_meter.sv
// Mirror zero-crossing period meter: measures, averages and lock-qualifies the zc interval.
// Optional level deglitch filter after the synchronizer: define MPM_DEGLITCH_EN.
module mirror_period_meter #(
  parameter int unsigned SYSCLOCK_P   = 500000000,
  parameter int unsigned MIN_TICKS_P  = 2000,
  parameter int unsigned MAX_TICKS_P  = 200000,
  parameter int unsigned AVG_LOG2_P   = 2,
  parameter int unsigned LOCK_TOL_P   = 64,
  parameter int unsigned LOCK_COUNT_P = 4,
  parameter int unsigned DEGLITCH_P   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        zc_i,
  input  logic        enable_i,
  output logic [23:0] freq_o,
  output logic        freq_valid_o,
  output logic        locked_o,
  output logic        zc_pulse_o,
  output logic        glitch_o,
  output logic        timeout_o
);

  localparam int unsigned CNT_W = 24;
  localparam int unsigned ACC_W = CNT_W + AVG_LOG2_P;
  localparam int unsigned BLK_W = AVG_LOG2_P;
  localparam int unsigned STB_W = $clog2(LOCK_COUNT_P + 1);

  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_TICKS_P);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_TICKS_P);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(LOCK_TOL_P);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'((1 << AVG_LOG2_P) - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_COUNT_P);

  if (MAX_TICKS_P > 32'h00FF_FFFF || MAX_TICKS_P <= MIN_TICKS_P || AVG_LOG2_P == 0 ||
      LOCK_COUNT_P == 0 || DEGLITCH_P == 0 || SYSCLOCK_P == 0) begin : g_bad_cfg
    $error("mirror_period_meter: invalid parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_MEAS, S_LOCK} state_t;

  state_t             state_q, state_d;
  logic               zc_meta_q, zc_sync_q, lvl_prev_q;
  logic               lvl_c, edge_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [STB_W-1:0]   stb_q, stb_d;
  logic               have_prev_q, have_prev_d;
  logic [CNT_W-1:0]   freq_q, freq_d;
  logic               valid_q, valid_d;
  logic               locked_q, locked_d;
  logic               zcp_q, zcp_d;
  logic               glitch_q, glitch_d;
  logic               timeout_q, timeout_d;

  logic               meas_c, accept_c, glitch_c, timeout_c, complete_c, stable_c, stb_sat_c;
  logic [ACC_W-1:0]   sum_c;
  logic [CNT_W-1:0]   avg_c, diff_c;
  logic [STB_W-1:0]   stb_inc_c;

`ifdef MPM_DEGLITCH_EN
  localparam int unsigned DG_W = $clog2(DEGLITCH_P + 1);
  logic            lvl_q;
  logic [DG_W-1:0] dg_cnt_q;

  // Synchronized level must disagree with the filtered level for DEGLITCH_P cycles to pass.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvl_q    <= 1'b0;
      dg_cnt_q <= '0;
    end else if (zc_sync_q == lvl_q) begin
      dg_cnt_q <= '0;
    end else if (dg_cnt_q == DG_W'(DEGLITCH_P - 1)) begin
      lvl_q    <= zc_sync_q;
      dg_cnt_q <= '0;
    end else begin
      dg_cnt_q <= dg_cnt_q + DG_W'(1);
    end
  end
  assign lvl_c = lvl_q;
`else
  assign lvl_c = zc_sync_q;
`endif

  assign edge_c     = lvl_c & ~lvl_prev_q;
  assign meas_c     = enable_i & ((state_q == S_MEAS) | (state_q == S_LOCK));
  assign accept_c   = meas_c & edge_c & (cnt_q >= MIN_C);
  assign glitch_c   = meas_c & edge_c & (cnt_q < MIN_C);
  assign timeout_c  = meas_c & ~edge_c & (cnt_q == MAX_C);
  assign complete_c = accept_c & (blk_q == BLK_LAST);
  assign sum_c      = acc_q + ACC_W'(cnt_q);
  assign avg_c      = CNT_W'(sum_c >> AVG_LOG2_P);
  assign diff_c     = (avg_c >= freq_q) ? (avg_c - freq_q) : (freq_q - avg_c);
  // freq_q always holds the previous average while have_prev_q is set
  assign stable_c   = have_prev_q & (diff_c <= TOL_C);
  assign stb_inc_c  = (stb_q == STB_LAST) ? stb_q : stb_q + STB_W'(1);
  assign stb_sat_c  = (stb_inc_c == STB_LAST);

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      zc_meta_q   <= 1'b0;
      zc_sync_q   <= 1'b0;
      lvl_prev_q  <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      blk_q       <= '0;
      stb_q       <= '0;
      have_prev_q <= 1'b0;
      freq_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      zcp_q       <= 1'b0;
      glitch_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      zc_meta_q   <= zc_i;
      zc_sync_q   <= zc_meta_q;
      lvl_prev_q  <= lvl_c;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      blk_q       <= blk_d;
      stb_q       <= stb_d;
      have_prev_q <= have_prev_d;
      freq_q      <= freq_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      zcp_q       <= zcp_d;
      glitch_q    <= glitch_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ACQ;
        S_ACQ:  if (edge_c) state_d = S_MEAS;
        S_MEAS, S_LOCK: begin
          if (complete_c) begin
            if (!stable_c)      state_d = S_MEAS;
            else if (stb_sat_c) state_d = S_LOCK;
          end else if (timeout_c) begin
            state_d = S_ACQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Counter, accumulator and registered-output next values
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    blk_d       = blk_q;
    stb_d       = stb_q;
    have_prev_d = have_prev_q;
    freq_d      = freq_q;
    valid_d     = 1'b0;
    zcp_d       = 1'b0;
    glitch_d    = 1'b0;
    timeout_d   = 1'b0;
    locked_d    = (state_d == S_LOCK);
    if (!enable_i || state_q == S_IDLE) begin
      cnt_d       = '0;
      acc_d       = '0;
      blk_d       = '0;
      stb_d       = '0;
      have_prev_d = 1'b0;
    end else if (state_q == S_ACQ) begin
      if (edge_c) begin
        cnt_d = CNT_W'(1);
        zcp_d = 1'b1;
      end
    end else begin
      cnt_d = (cnt_q == MAX_C) ? cnt_q : cnt_q + CNT_W'(1);
      if (glitch_c) begin
        glitch_d = 1'b1;
      end else if (accept_c) begin
        zcp_d = 1'b1;
        cnt_d = CNT_W'(1);
        if (complete_c) begin
          freq_d      = avg_c;
          valid_d     = 1'b1;
          acc_d       = '0;
          blk_d       = '0;
          have_prev_d = 1'b1;
          stb_d       = stable_c ? stb_inc_c : '0;
        end else begin
          acc_d = sum_c;
          blk_d = blk_q + BLK_W'(1);
        end
      end else if (timeout_c) begin
        timeout_d   = 1'b1;
        cnt_d       = '0;
        acc_d       = '0;
        blk_d       = '0;
        stb_d       = '0;
        have_prev_d = 1'b0;
      end
    end
  end

  assign freq_o       = freq_q;
  assign freq_valid_o = valid_q;
  assign locked_o     = locked_q;
  assign zc_pulse_o   = zcp_q;
  assign glitch_o     = glitch_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_mirror_period_meter.sv
// Bench for mirror_period_meter with scaled-down tick parameters to keep runtime short.
`timescale 1ns/1ps
module tb_mirror_period_meter;

  localparam int unsigned MIN_T = 80;
  localparam int unsigned MAX_T = 8000;

  logic        clk = 1'b0;
  logic        rst_i, zc_i, enable_i;
  logic [23:0] freq_o;
  logic        freq_valid_o, locked_o, zc_pulse_o, glitch_o, timeout_o;

  mirror_period_meter #(
    .SYSCLOCK_P(500000000), .MIN_TICKS_P(MIN_T), .MAX_TICKS_P(MAX_T), .AVG_LOG2_P(2),
    .LOCK_TOL_P(3), .LOCK_COUNT_P(4), .DEGLITCH_P(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .zc_i(zc_i), .enable_i(enable_i),
    .freq_o(freq_o), .freq_valid_o(freq_valid_o), .locked_o(locked_o),
    .zc_pulse_o(zc_pulse_o), .glitch_o(glitch_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned period; bit glitch; logic [23:0] exp_freq; logic exp_lock; } vec_t;
  typedef struct { logic [23:0] f; logic l; } exp_t;

  vec_t  vecs[11];
  exp_t  sb_q[$];
  int    n_checks = 0, n_fail = 0;
  int    n_zc = 0, n_glitch = 0, n_timeout = 0;
  longint cyc = 0, last_zc_cyc = 0, timeout_cyc = 0;
  logic [23:0] freq_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle zc pulse; the next rise lands `period` cycles after this one when followed by wait_cyc(period-1)
  task automatic pulse();
    zc_i = 1'b1;
    @(negedge clk);
    zc_i = 1'b0;
  endtask

  task automatic push(input logic [23:0] f, input logic l);
    exp_t e;
    e.f = f;
    e.l = l;
    sb_q.push_back(e);
  endtask

  // Output monitor and scoreboard
  always @(posedge clk) begin
    #1;
    cyc++;
    if (zc_pulse_o) begin n_zc++; last_zc_cyc = cyc; end
    if (glitch_o) n_glitch++;
    if (timeout_o) begin n_timeout++; timeout_cyc = cyc; end
    if (freq_valid_o) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_freq_valid: got freq %0d with no expected update", freq_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_freq", 32'(freq_o), 32'(e.f));
        check("sb_locked", 32'(locked_o), 32'(e.l));
      end
    end
    if (!rst_i && freq_o !== freq_prev) check("freq_changes_with_valid", 32'(freq_valid_o), 32'd1);
    freq_prev = freq_o;
  end

  initial begin
    int base_zc;
    vecs[0]  = '{1000, 1'b0, 24'd1000, 1'b0};
    vecs[1]  = '{1000, 1'b0, 24'd1000, 1'b0};
    vecs[2]  = '{1000, 1'b0, 24'd1000, 1'b0};
    vecs[3]  = '{1000, 1'b0, 24'd1000, 1'b0};
    vecs[4]  = '{1000, 1'b0, 24'd1000, 1'b1};
    vecs[5]  = '{1000, 1'b1, 24'd1000, 1'b1};
    vecs[6]  = '{1004, 1'b0, 24'd1004, 1'b0};
    vecs[7]  = '{1004, 1'b0, 24'd1004, 1'b0};
    vecs[8]  = '{1004, 1'b0, 24'd1004, 1'b0};
    vecs[9]  = '{1004, 1'b0, 24'd1004, 1'b0};
    vecs[10] = '{1004, 1'b0, 24'd1004, 1'b1};

    rst_i = 1'b1; enable_i = 1'b0; zc_i = 1'b0;
    wait_cyc(4);
    check("rst_freq", 32'(freq_o), 32'd0);
    check("rst_valid", 32'(freq_valid_o), 32'd0);
    check("rst_locked", 32'(locked_o), 32'd0);
    check("rst_zc_pulse", 32'(zc_pulse_o), 32'd0);
    check("rst_glitch", 32'(glitch_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    rst_i = 1'b0; enable_i = 1'b1;
    wait_cyc(4);

    // Steady period, glitch, and period step: each row is one block of four intervals
    pulse();
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 0 && vecs[i].glitch) begin
          wait_cyc(49);
          check("before_glitch_count", 32'(n_zc), 32'(1 + 4 * i));
          pulse();
          wait_cyc(vecs[i].period - 51);
        end else begin
          wait_cyc(vecs[i].period - 1);
          if (k == 0) check("accepted_edges", 32'(n_zc), 32'(1 + 4 * i));
        end
        if (k == 3) push(vecs[i].exp_freq, vecs[i].exp_lock);
        pulse();
      end
      if (i == 6) check("single_glitch", 32'(n_glitch), 32'd1);
    end

    // Loss of mirror: timeout exactly MAX_T ticks after the last accepted edge
    for (int t = 0; t < int'(MAX_T) + 100 && n_timeout == 0; t++) wait_cyc(1);
    check("timeout_seen", 32'(n_timeout), 32'd1);
    check("timeout_delay", 32'(timeout_cyc - last_zc_cyc), 32'(MAX_T));
    check("timeout_unlock", 32'(locked_o), 32'd0);
    check("timeout_freq_hold", 32'(freq_o), 32'd1004);

    // Disable mid-block drops the partial block; five fresh edges give a new, unlocked average
    wait_cyc(5);
    pulse(); wait_cyc(999); pulse(); wait_cyc(999); pulse();
    wait_cyc(500);
    enable_i = 1'b0;
    wait_cyc(5);
    check("disable_locked", 32'(locked_o), 32'd0);
    enable_i = 1'b1;
    wait_cyc(5);
    pulse();
    for (int k = 0; k < 4; k++) begin
      wait_cyc(999);
      if (k == 3) push(24'd1000, 1'b0);
      pulse();
    end

    // Reset mid-block clears freq_o
    wait_cyc(999); pulse(); wait_cyc(999); pulse();
    wait_cyc(500);
    rst_i = 1'b1;
    wait_cyc(2);
    rst_i = 1'b0;
    check("midrst_freq", 32'(freq_o), 32'd0);
    check("midrst_locked", 32'(locked_o), 32'd0);
    check("midrst_valid", 32'(freq_valid_o), 32'd0);

    // Edge on the cycle the counter reaches MAX_T is accepted, not a timeout
    wait_cyc(5);
    base_zc = n_zc;
    pulse(); wait_cyc(MAX_T - 1); pulse();
    wait_cyc(10);
    check("max_edge_accepted", 32'(n_zc), 32'(base_zc + 2));
    check("max_edge_no_timeout", 32'(n_timeout), 32'd1);
    wait_cyc(989); pulse();
    wait_cyc(999); pulse();
    wait_cyc(999); push(24'd2750, 1'b0); pulse();

    wait_cyc(20);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check("total_glitches", 32'(n_glitch), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
